dac_output_shaper: RTL
======================

# dac_output_shaper

Streaming stage placed directly downstream of the waveform `signal_generator`, between it and the DAC interface. It consumes the generator's 16-bit signed sample stream and applies a configurable amplitude gain. It then applies a soft-start/soft-stop envelope ramp and a DC offset, and saturates the result to the symmetric DAC range ±8191. This prevents hard steps at DAC enable/disable and keeps out-of-range values off the converter.

## Interface
- `AXIS_TDATA_WIDTH`, 16, width of the input and output stream words (signed samples).
- `DAC_WIDTH`, 14, width of the DAC code. The output is saturated to ±(2^(DAC_WIDTH-1)-1) and sign-extended to `AXIS_TDATA_WIDTH`.
- `clk`  in  1  single clock for all logic.
- `aresetn`  in  1  asynchronous active-low reset.
- `s_axis_tvalid`  in  1  input sample valid.
- `s_axis_tdata`  in  16  input sample, signed two's complement.
- `s_axis_tready`  out  1  constant 1; the block never back-pressures.
- `enable`  in  1  level-sensitive request for output on (1) or off (0).
- `cfg_amplitude`  in  16  unsigned gain, where 32768 = 1.0 (gain = value/2^15).
- `cfg_offset`  in  14  signed DC offset in DAC codes.
- `cfg_ramp_step`  in  16  unsigned envelope increment or decrement per accepted sample.
- `m_axis_tvalid`  out  1  output sample valid.
- `m_axis_tdata`  out  16  saturated output sample, sign-extended.
- `state`  out  2  envelope state: IDLE=00, RAMP_UP=01, RUN=10, RAMP_DOWN=11.
- `clip_count`  out  32  number of saturated output samples (see Configuration).

## Operation
- Envelope register `env` is 17 bits unsigned, range 0..65536; 65536 represents 1.0.
- `env` and `state` advance only on accepted samples (`s_axis_tvalid`=1). `enable` is sampled on those cycles.
- State machine:
  - IDLE: `env`=0. If `enable`=1, go to RAMP_UP.
  - RAMP_UP: if `enable`=0, go to RAMP_DOWN with `env` unchanged. Otherwise, if `env`+step ≥ 65536, set `env`=65536 and go to RUN; else `env` += step.
  - RUN: `env`=65536. If `enable`=0, go to RAMP_DOWN.
  - RAMP_DOWN: if `enable`=1, go to RAMP_UP with `env` unchanged. Otherwise, if `env` ≤ step, set `env`=0 and go to IDLE; else `env` -= step.
- `cfg_ramp_step`=0 means an instantaneous ramp: RAMP_UP reaches 65536 and RAMP_DOWN reaches 0 on the first accepted sample.
- Datapath, with all shifts arithmetic (floor):
  - Stage 1: `a` = (`s_axis_tdata` × `cfg_amplitude`) >>> 15. `a` is 18 bits signed.
  - Stage 2: `b` = (`a` × `env`) >>> 16. `env` is the register value in the cycle the sample enters stage 2.
  - Stage 3: `c` = `b` + `cfg_offset` at full width. Clamp `c` to [-8191, +8191], then sign-extend to 16 bits.
- In IDLE the output equals the saturated `cfg_offset`.
- The `cfg_*` inputs are quasi-static and sampled every cycle with no synchronisation. A change affects samples from the next stage entry onward; no glitch filtering is applied.

## Timing
- Latency is 3 clk cycles from an accepted input to the corresponding `m_axis_tvalid`=1.
- The `m_axis_tvalid` pipeline is a shift of `s_axis_tvalid`. A gap in the input produces a gap in the output of equal length. Pipeline data holds during gaps.
- With `s_axis_tvalid` constantly 1 (the normal generator case), one output is produced per cycle.
- Reset values: `m_axis_tvalid`=0, `m_axis_tdata`=0, `state`=IDLE, `env`=0, all pipeline registers 0, `clip_count`=0. `s_axis_tready` stays 1.
- Reset asserted mid-ramp clears everything immediately and asynchronously. After release the block starts from IDLE and ramps again if `enable`=1.
- When `enable` toggles in the same cycle as a ramp end condition, the `enable` branch takes priority, as ordered above.

## Configuration
- `DAC_OUTPUT_SHAPER_CLIP_COUNT_EN` defined:
  - `clip_count` increments on each `m_axis_tvalid` sample whose stage-3 value was clamped.
  - The counter saturates at 2^32-1 and is cleared only by reset.
- `DAC_OUTPUT_SHAPER_CLIP_COUNT_EN` undefined:
  - `clip_count` is tied to 0 and no counter logic is built.
  - Datapath and clamping behaviour are identical to the defined case.

## Test plan
- Reset with `aresetn`=0 and inputs active → all outputs 0 and `state`=00. After release with `enable`=0 and `cfg_offset`=0, `s_axis_tvalid`=1 → output 0 from cycle 3 onward.
- `cfg_amplitude`=32768, `cfg_offset`=0, `cfg_ramp_step`=16384, input constant 8000, then `enable` set to 1 → `env` steps 16384, 32768, 49152, 65536 and the output sequence 2000, 4000, 6000, 8000 holds at 8000. `state` goes 01 then 10.
- In RUN with `cfg_amplitude`=65535 and input ±8191 → output +8191 / -8191 every cycle; `clip_count` increments by 1 per sample (macro defined) or stays 0 (undefined).
- IDLE, `cfg_offset`=-100, input 5000 → output -100. With `cfg_offset`=-8192 → output -8191 and the clip count increments.
- Ramp step 16384, `enable` dropped when `env`=32768 → `state`=11 and `env` goes 16384, 0, then IDLE. Re-asserting `enable` at 16384 → back to 01 from 16384.
- `cfg_ramp_step`=0, input 1000, `enable`=1 → after the IDLE→RAMP_UP transition, RUN follows on the next sample. The output jumps directly 0→1000, and input tvalid gaps of 2 cycles appear as identical output gaps.

Source files
------------

// File: rtl/dac_output_shaper.sv
// dac_output_shaper: gain, soft-start/soft-stop envelope, DC offset and symmetric DAC saturation
// on a signed sample stream. Define DAC_OUTPUT_SHAPER_CLIP_COUNT_EN to build the clip_count counter.
module dac_output_shaper #(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int DAC_WIDTH        = 14
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic                        s_axis_tvalid,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                        s_axis_tready,
  input  logic                        enable,
  input  logic [15:0]                 cfg_amplitude,
  input  logic [DAC_WIDTH-1:0]        cfg_offset,
  input  logic [15:0]                 cfg_ramp_step,
  output logic                        m_axis_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]                  state,
  output logic [31:0]                 clip_count
);
  localparam int P1_W = AXIS_TDATA_WIDTH + 17;
  localparam int A_W  = AXIS_TDATA_WIDTH + 2;
  localparam int P2_W = A_W + 18;
  localparam int C_W  = A_W + 1;
  localparam logic [16:0] ENV_ONE = 17'h10000;
  localparam logic signed [C_W-1:0] DAC_MAX = C_W'(2 ** (DAC_WIDTH - 1) - 1);
  localparam logic signed [C_W-1:0] DAC_MIN = -DAC_MAX;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RAMP_UP   = 2'b01,
    RUN       = 2'b10,
    RAMP_DOWN = 2'b11
  } env_state_t;

  env_state_t             state_q;
  logic [16:0]            env_q;
  logic                   v1_q, v2_q;
  logic signed [A_W-1:0]  a_q, b_q;
  logic signed [P1_W-1:0] prod1;
  logic signed [P2_W-1:0] prod2;
  logic signed [C_W-1:0]  c_next, c_sat;
  logic                   clip_hi, clip_lo;
  logic [17:0]            env_up;
  logic                   env_up_full, env_down_empty;

  // Handshake: the stage never stalls, so every cycle with s_axis_tvalid=1 is an accepted
  // sample; m_axis_tvalid is that valid delayed by three clocks and has no ready input.
  assign s_axis_tready = 1'b1;
  assign state         = state_q;

  // A zero step means an instantaneous ramp in either direction.
  assign env_up         = {1'b0, env_q} + {2'b00, cfg_ramp_step};
  assign env_up_full    = (cfg_ramp_step == 16'd0) || (env_up >= 18'h10000);
  assign env_down_empty = (cfg_ramp_step == 16'd0) || (env_q <= {1'b0, cfg_ramp_step});

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      env_q   <= '0;
    end else if (s_axis_tvalid) begin
      case (state_q)
        IDLE: begin
          env_q <= '0;
          if (enable) state_q <= RAMP_UP;
        end
        RAMP_UP: begin
          if (!enable) begin
            state_q <= RAMP_DOWN;
          end else if (env_up_full) begin
            env_q   <= ENV_ONE;
            state_q <= RUN;
          end else begin
            env_q <= env_up[16:0];
          end
        end
        RUN: begin
          env_q <= ENV_ONE;
          if (!enable) state_q <= RAMP_DOWN;
        end
        RAMP_DOWN: begin
          if (enable) begin
            state_q <= RAMP_UP;
          end else if (env_down_empty) begin
            env_q   <= '0;
            state_q <= IDLE;
          end else begin
            env_q <= env_q - {1'b0, cfg_ramp_step};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prod1  = P1_W'($signed(s_axis_tdata)) * P1_W'($signed({1'b0, cfg_amplitude}));
  assign prod2  = P2_W'(a_q) * P2_W'($signed({1'b0, env_q}));
  assign c_next = C_W'(b_q) + C_W'($signed(cfg_offset));

  assign clip_hi = (c_next > DAC_MAX);
  assign clip_lo = (c_next < DAC_MIN);
  assign c_sat   = clip_hi ? DAC_MAX : (clip_lo ? DAC_MIN : c_next);

  // Each stage register loads only with its valid, so data holds across input gaps.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      v1_q          <= 1'b0;
      v2_q          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      m_axis_tdata  <= '0;
    end else begin
      v1_q          <= s_axis_tvalid;
      v2_q          <= v1_q;
      m_axis_tvalid <= v2_q;
      if (s_axis_tvalid) a_q <= A_W'(prod1 >>> 15);
      if (v1_q)          b_q <= A_W'(prod2 >>> 16);
      if (v2_q)          m_axis_tdata <= AXIS_TDATA_WIDTH'(c_sat);
    end
  end

`ifdef DAC_OUTPUT_SHAPER_CLIP_COUNT_EN
  logic [31:0] clip_q;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      clip_q <= '0;
    end else if (v2_q && (clip_hi || clip_lo) && (clip_q != 32'hFFFF_FFFF)) begin
      clip_q <= clip_q + 32'd1;
    end
  end

  assign clip_count = clip_q;
`else
  assign clip_count = '0;
`endif

endmodule
